dm_arbiter: RTL and testbench

Single-port data-memory arbiter shared by the pipeline Mem stage (CPU port) and a block-transfer engine (DMA port). It sits between both requesters and the DM instance and drives DM address, write data, write enable and write-PC. CPU accesses are single-cycle with priority. DMA accesses are bursts of consecutive words. A pause counter bounds DMA starvation, and the CPU is stalled only when the DMA beat is forced.

---
 rtl/dm_arbiter.sv | 102 ++++++++++
 tb/tb_dm_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one DM port between single-cycle CPU accesses and bounded-starvation DMA bursts
module dm_arbiter #(
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned DMA_WAIT_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_beat,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, ACCEPT, BURST} state_t;
  localparam logic [3:0] MAX_LEN  = 4'(MAX_BURST);
  localparam logic [2:0] WAIT_MAX = 3'(DMA_WAIT_MAX);
  state_t      state;
  logic [29:0] base;
  logic        dir;
  logic [3:0]  remaining;
  logic [3:0]  index;
  logic [2:0]  pause_cnt;
  logic [3:0]  eff_len;
  logic [29:0] beat_addr;
  logic        force_beat;
  logic        cpu_own;
  logic [3:0]  unused_bits;
  assign unused_bits = {cpu_addr[1:0], dma_addr[1:0]};
  assign cpu_rdata   = dm_rdata;
  assign dma_rdata   = dm_rdata;
  // ownership and DM port mux; the DMA wins in BURST when the CPU is idle or the pause limit is hit
  always_comb begin
    eff_len    = dma_len == 4'd0 ? 4'd1 : (dma_len > MAX_LEN ? MAX_LEN : dma_len);
    force_beat = pause_cnt == WAIT_MAX;
    dma_beat   = reset && state == BURST && (!cpu_req || force_beat);
    cpu_own    = reset && cpu_req && !dma_beat;
    cpu_stall  = cpu_req && dma_beat;
    beat_addr  = base + {26'd0, index};
    dm_addr    = dma_beat ? {beat_addr, 2'b00} : (cpu_own ? {cpu_addr[31:2], 2'b00} : 32'h0);
    dm_wdata   = dma_beat ? dma_wdata : (cpu_own ? cpu_wdata : 32'h0);
    dm_we      = dma_beat ? dir : (cpu_own && cpu_we);
    dm_pc      = cpu_own ? cpu_pc : 32'h0;
  end
  // burst sequencing: accept in IDLE, one settle cycle, then beats until the count runs out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base      <= '0;
      dir       <= 1'b0;
      remaining <= '0;
      index     <= '0;
      pause_cnt <= '0;
      dma_gnt   <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      dma_gnt  <= 1'b0;
      dma_done <= 1'b0;
      case (state)
        IDLE:
          if (dma_req && !cpu_req) begin
            base      <= dma_addr[31:2];
            dir       <= dma_we;
            remaining <= eff_len;
            index     <= '0;
            dma_gnt   <= 1'b1;
            state     <= ACCEPT;
          end
        ACCEPT: begin
          pause_cnt <= '0;
          state     <= BURST;
        end
        BURST:
          if (dma_beat) begin
            pause_cnt <= '0;
            index     <= index + 4'd1;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) begin
              state    <= IDLE;
              dma_done <= 1'b1;
            end
          end else if (cpu_req) pause_cnt <= pause_cnt + 3'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a small behavioural DM
module tb_dm_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_pc = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [3:0]  dma_len = '0;
  logic        dma_gnt, dma_beat, dma_done;
  logic [31:0] dma_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic        dm_we;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic        chk;
  } beat_t;
  beat_t exp_q[$];
  logic [31:0] mem [0:63];
  dm_arbiter #(.MAX_BURST(8), .DMA_WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_pc(cpu_pc), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_beat(dma_beat), .dma_rdata(dma_rdata),
    .dma_done(dma_done), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );
  always #5 clk = ~clk;
  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;
  // every DMA beat is matched in order against the expected beats queued by the scenario
  always @(negedge clk) begin
    beat_t e;
    if (reset && dma_beat) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected addr=%h we=%0d", dm_addr, dm_we);
      end else begin
        e = exp_q.pop_front();
        if (dm_addr !== e.addr || dm_we !== e.we || dm_pc !== 32'h0 ||
            (e.chk && (e.we ? dm_wdata : dma_rdata) !== e.data)) begin
          failures++;
          $display("FAIL beat got addr=%h we=%0d wdata=%h rdata=%h pc=%h want addr=%h we=%0d data=%h",
                   dm_addr, dm_we, dm_wdata, dma_rdata, dm_pc, e.addr, e.we, e.data);
        end
      end
    end
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h1;
    dma_req = 1; dma_we = 1; dma_len = 4'd4; dma_addr = 32'h40;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({dm_we, cpu_stall, dma_gnt, dma_done, dma_beat} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs got we,stall,gnt,done,beat=%b want 00000",
                 {dm_we, cpu_stall, dma_gnt, dma_done, dma_beat});
      end
    end
    nxt();
    dma_req = 0; reset = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_pc = 32'h400;
    @(negedge clk);
    checks++;
    if (cpu_stall !== 0 || dm_we !== 1 || dm_addr !== 32'h10 || dm_wdata !== 32'hDEADBEEF || dm_pc !== 32'h400) begin
      failures++;
      $display("FAIL cpu_store got stall=%0d we=%0d addr=%h wdata=%h pc=%h want 0 1 00000010 deadbeef 00000400",
               cpu_stall, dm_we, dm_addr, dm_wdata, dm_pc);
    end
    nxt();
    cpu_we = 0; cpu_addr = 32'h13;
    @(negedge clk);
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF || dm_addr !== 32'h10 || dm_we !== 0) begin
      failures++;
      $display("FAIL cpu_load got rdata=%h addr=%h we=%0d want deadbeef 00000010 0", cpu_rdata, dm_addr, dm_we);
    end
    nxt();
    cpu_req = 0;
  endtask
  task automatic test_dma_write();
    logic [31:0] wd [3];
    int k = 0;
    wd[0] = 32'hA0A00001; wd[1] = 32'hB0B00002; wd[2] = 32'hC0C00003;
    for (int i = 0; i < 3; i++) exp_q.push_back('{32'h100 + 32'(4 * i), 1'b1, wd[i], 1'b1});
    for (int c = 0; c < 7; c++) begin
      dma_req = c < 2; dma_we = 1; dma_addr = 32'h100; dma_len = 4'd3; dma_wdata = wd[k < 3 ? k : 2];
      @(negedge clk);
      checks++;
      if (dma_gnt !== (c == 1) || dma_done !== (c == 5) || dma_beat !== (c >= 2 && c <= 4) || cpu_stall !== 0) begin
        failures++;
        $display("FAIL dma_write_timing cycle=%0d got gnt=%0d beat=%0d done=%0d stall=%0d", c, dma_gnt, dma_beat, dma_done, cpu_stall);
      end
      if (dma_beat) k++;
      nxt();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL dma_write_beats got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
    @(negedge clk);
    checks++;
    if (cpu_rdata !== wd[1] || cpu_stall !== 0) begin
      failures++;
      $display("FAIL dma_write_readback got %h want %h", cpu_rdata, wd[1]);
    end
    nxt();
    cpu_req = 0;
  endtask
  task automatic test_simultaneous();
    exp_q.push_back('{32'h100, 1'b0, 32'hA0A00001, 1'b1});
    for (int c = 0; c < 7; c++) begin
      cpu_req = c < 3; cpu_we = 0; cpu_addr = 32'h104;
      dma_req = c < 5; dma_we = 0; dma_addr = 32'h102; dma_len = 4'd0;
      @(negedge clk);
      checks++;
      if (dma_gnt !== (c == 4) || dma_beat !== (c == 5) || dma_done !== (c == 6) || cpu_stall !== 0 ||
          (c < 3 && (dm_addr !== 32'h104 || cpu_rdata !== 32'hB0B00002))) begin
        failures++;
        $display("FAIL simultaneous cycle=%0d got gnt=%0d beat=%0d done=%0d stall=%0d addr=%h", c, dma_gnt, dma_beat, dma_done, cpu_stall, dm_addr);
      end
      nxt();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL simultaneous_beats got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_starvation();
    logic eb;
    exp_q.push_back('{32'h300, 1'b0, 32'h0, 1'b0});
    exp_q.push_back('{32'h304, 1'b0, 32'h0, 1'b0});
    for (int c = 0; c < 14; c++) begin
      dma_req = c < 2; dma_we = 0; dma_addr = 32'h300; dma_len = 4'd2;
      cpu_req = c >= 1; cpu_we = 0; cpu_addr = 32'h100 + 32'(4 * (c % 3)); cpu_pc = 32'(c);
      eb = c == 6 || c == 11;
      @(negedge clk);
      checks++;
      if (dma_beat !== eb || cpu_stall !== eb || dma_gnt !== (c == 1) || dma_done !== (c == 12) ||
          (!eb && c >= 1 && (dm_addr !== cpu_addr || dm_pc !== cpu_pc))) begin
        failures++;
        $display("FAIL starvation cycle=%0d got beat=%0d stall=%0d gnt=%0d done=%0d addr=%h want beat=stall=%0d",
                 c, dma_beat, cpu_stall, dma_gnt, dma_done, dm_addr, eb);
      end
      nxt();
    end
    cpu_req = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL starvation_beats got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_clamp_wrap();
    int k = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back('{32'hFFFFFFFC + 32'(4 * i), 1'b1, 32'h50000000 + 32'(i), 1'b1});
    for (int c = 0; c < 12; c++) begin
      dma_req = c < 2; dma_we = 1; dma_addr = 32'hFFFFFFFF; dma_len = 4'hF; dma_wdata = 32'h50000000 + 32'(k);
      @(negedge clk);
      checks++;
      if (dma_gnt !== (c == 1) || dma_beat !== (c >= 2 && c <= 9) || dma_done !== (c == 10)) begin
        failures++;
        $display("FAIL clamp_wrap cycle=%0d got gnt=%0d beat=%0d done=%0d", c, dma_gnt, dma_beat, dma_done);
      end
      if (dma_beat) k++;
      nxt();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL clamp_wrap_beats got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_mid_reset();
    exp_q.push_back('{32'h400, 1'b0, 32'h0, 1'b0});
    exp_q.push_back('{32'h404, 1'b0, 32'h0, 1'b0});
    for (int c = 0; c < 4; c++) begin
      dma_req = c < 2; dma_we = 0; dma_addr = 32'h400; dma_len = 4'd6;
      @(negedge clk);
      checks++;
      if (dma_beat !== (c >= 2) || dma_gnt !== (c == 1)) begin
        failures++;
        $display("FAIL mid_reset_start cycle=%0d got beat=%0d gnt=%0d", c, dma_beat, dma_gnt);
      end
      nxt();
    end
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({dma_beat, dm_we, dma_gnt, dma_done, cpu_stall} !== 5'b0) begin
        failures++;
        $display("FAIL mid_reset_held got beat,we,gnt,done,stall=%b want 00000", {dma_beat, dm_we, dma_gnt, dma_done, cpu_stall});
      end
    end
    nxt();
    reset = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (dma_beat !== 0 || dma_done !== 0 || dma_gnt !== 0) begin
        failures++;
        $display("FAIL mid_reset_after cycle=%0d got beat=%0d done=%0d gnt=%0d want 0 0 0", c, dma_beat, dma_done, dma_gnt);
      end
      nxt();
    end
    exp_q.push_back('{32'h500, 1'b1, 32'h77, 1'b1});
    for (int c = 0; c < 4; c++) begin
      dma_req = c < 2; dma_we = 1; dma_addr = 32'h500; dma_len = 4'd1; dma_wdata = 32'h77;
      @(negedge clk);
      checks++;
      if (dma_gnt !== (c == 1) || dma_beat !== (c == 2) || dma_done !== (c == 3)) begin
        failures++;
        $display("FAIL mid_reset_rerequest cycle=%0d got gnt=%0d beat=%0d done=%0d", c, dma_gnt, dma_beat, dma_done);
      end
      nxt();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_beats got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    test_reset();
    test_dma_write();
    test_simultaneous();
    test_starvation();
    test_clamp_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
